// File: rtl/mc_pkg.sv
// mc_pkg: shared types, constants and latency lookup for the multi-cycle FP scheduler
package mc_pkg;

    typedef enum logic [1:0] {OP_NONE, OP_MUL, OP_DIV, OP_SQRT} mc_op_t;
    typedef enum logic [1:0] {IDLE, RUN, WAIT_WB} mc_state_t;

    localparam logic [5:0] REG_ZERO = 6'd0;

    function automatic logic [4:0] lat_of(mc_op_t op, int lat_div, int lat_sqrt, int lat_mul);
        return op == OP_DIV ? 5'(lat_div) : op == OP_SQRT ? 5'(lat_sqrt) : 5'(lat_mul);
    endfunction

endpackage

// File: rtl/mc_scheduler.sv
// mc_scheduler: sequences the shared multi-cycle FP unit, arbitrates the RF write port, raises stalls
module mc_scheduler
    import mc_pkg::*;
#(
    parameter int LAT_DIV  = 10,
    parameter int LAT_SQRT = 12,
    parameter int LAT_MUL  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  mc_op_t     issue_op,
    input  logic [5:0] issue_rd,
    input  logic [5:0] rs1D,
    input  logic [5:0] rs2D,
    input  logic [5:0] rdD,
    input  logic       reg_writeD,
    input  logic       reg_writeW,
    output logic       unit_start,
    output logic       issue_stall,
    output logic       raw_stall,
    output logic       busy,
    output logic       wb_en,
    output logic [5:0] wb_rd
);

    if (LAT_DIV < 2 || LAT_DIV > 31 || LAT_SQRT < 2 || LAT_SQRT > 31 || LAT_MUL < 2 || LAT_MUL > 31) begin : g_bad_lat
        $error("mc_scheduler: every LAT_* must lie in 2..31");
    end

    mc_state_t  state, next_state;
    logic [4:0] cnt;
    logic [5:0] pend_rd;
    logic [5:0] hz_rd;
    logic       accept;
    logic       done;
    logic       wb_fire;

    // cnt holds the cycles left before wb_en; done marks the last RUN cycle so wb_en lands exactly LAT after start
    assign done    = state == RUN && cnt == 5'd1;
    assign wb_fire = (done || state == WAIT_WB) && !reg_writeW;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // next-state: the main pipeline always wins the write port, parking a finished result in WAIT_WB
    always_comb begin
        next_state = state == IDLE    ? (accept ? RUN : IDLE) :
                     state == RUN     ? (done ? (reg_writeW ? WAIT_WB : IDLE) : RUN) :
                     state == WAIT_WB ? (reg_writeW ? WAIT_WB : IDLE) : IDLE;
    end

    // outputs: start strobe, structural stall and RAW/WAW stall against the pending (or accepting) destination
    always_comb begin
        accept      = state == IDLE && issue_valid && issue_op != OP_NONE;
        unit_start  = accept;
        busy        = state != IDLE;
        issue_stall = issue_valid && state != IDLE;
        hz_rd       = state != IDLE ? pend_rd : accept ? issue_rd : REG_ZERO;
        raw_stall   = hz_rd != REG_ZERO && (rs1D == hz_rd || rs2D == hz_rd || (reg_writeD && rdD == hz_rd));
    end

    // datapath: latency counter, pending destination and the registered write-port grant
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            pend_rd <= REG_ZERO;
            wb_en   <= 1'b0;
            wb_rd   <= REG_ZERO;
        end else begin
            wb_en <= wb_fire;
            if (wb_fire) wb_rd <= pend_rd;
            if (accept) begin
                pend_rd <= issue_rd;
                cnt     <= lat_of(issue_op, LAT_DIV, LAT_SQRT, LAT_MUL) - 5'd1;
            end else if (state == RUN) begin
                cnt <= cnt - 5'd1;
            end
        end
    end

endmodule
